// File: rtl/rank_filter_3x3_if.sv
// Column-in / result-out signal bundle for rank_filter_3x3.
// master drives columns and control; slave is the filter.
interface rank_filter_3x3_if #(
    parameter int PIX_W = 5
) ();
    logic             in_valid;
    logic [PIX_W-1:0] pixel_in0;
    logic [PIX_W-1:0] pixel_in1;
    logic [PIX_W-1:0] pixel_in2;
    logic [1:0]       mode;
    logic             flush;
    logic             out_valid;
    logic [PIX_W-1:0] pixel_out;
    logic             band_done;

    modport master (
        output in_valid, pixel_in0, pixel_in1, pixel_in2, mode, flush,
        input  out_valid, pixel_out, band_done
    );

    modport slave (
        input  in_valid, pixel_in0, pixel_in1, pixel_in2, mode, flush,
        output out_valid, pixel_out, band_done
    );
endinterface

// File: rtl/rank_filter_3x3.sv
// Sliding 3x3 rank-order filter (median / min / max / centre) over a row band of IMG_W columns.
// Optional macro RANK_FILTER_PIPE_EN adds a register inside the median network (latency 2 edges).
module rank_filter_3x3 #(
    parameter int PIX_W = 5,
    parameter int IMG_W = 16,
    parameter int CNT_W = $clog2(IMG_W)
) (
    input logic              clk,
    input logic              reset,
    rank_filter_3x3_if.slave bus
);
    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [2:0]       col_t;
    typedef pix_t [8:0]       win_t;

    localparam logic [CNT_W-1:0] LAST_COL   = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] FIRST_FULL = CNT_W'(2);

    function automatic win_t cas(input win_t v, input logic [3:0] a, input logic [3:0] b);
        win_t r = v;
        r[a] = (v[a] > v[b]) ? v[b] : v[a];
        r[b] = (v[a] > v[b]) ? v[a] : v[b];
        return r;
    endfunction

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    // Stages 1-4 of the 19-exchange median network; output is a permutation of the input.
    function automatic win_t net_front(input win_t v);
        win_t s = v;
        s = cas(s, 4'd1, 4'd2); s = cas(s, 4'd4, 4'd5); s = cas(s, 4'd7, 4'd8);
        s = cas(s, 4'd0, 4'd1); s = cas(s, 4'd3, 4'd4); s = cas(s, 4'd6, 4'd7);
        s = cas(s, 4'd1, 4'd2); s = cas(s, 4'd4, 4'd5); s = cas(s, 4'd7, 4'd8);
        s = cas(s, 4'd0, 4'd3); s = cas(s, 4'd5, 4'd8); s = cas(s, 4'd4, 4'd7);
        return s;
    endfunction

    function automatic pix_t net_back(input win_t v);
        win_t s = v;
        s = cas(s, 4'd3, 4'd6); s = cas(s, 4'd1, 4'd4); s = cas(s, 4'd2, 4'd5);
        s = cas(s, 4'd4, 4'd7); s = cas(s, 4'd4, 4'd2); s = cas(s, 4'd6, 4'd4);
        s = cas(s, 4'd4, 4'd2);
        return s[4];
    endfunction

    function automatic pix_t tree_min(input win_t v);
        return min2(min2(min2(v[0], v[1]), min2(v[2], v[3])),
                    min2(min2(v[4], v[5]), min2(min2(v[6], v[7]), v[8])));
    endfunction

    function automatic pix_t tree_max(input win_t v);
        return max2(max2(max2(v[0], v[1]), max2(v[2], v[3])),
                    max2(max2(v[4], v[5]), max2(max2(v[6], v[7]), v[8])));
    endfunction

    col_t             col0_r, col1_r, col2_r, col_in_s;
    logic [CNT_W-1:0] ccnt_r, ccnt_nxt_s;
    logic             accept_s, complete_s, last_s;
    logic             win_vld_r, win_done_r;
    logic [1:0]       win_mode_r;
    win_t             win_s, front_s, back_in_s;
    pix_t             centre_s, result_s;
    logic [1:0]       res_mode_s;
    logic             res_vld_s, res_done_s;
    logic             out_valid_r, band_done_r;
    pix_t             pixel_out_r;

    assign col_in_s   = {bus.pixel_in2, bus.pixel_in1, bus.pixel_in0};
    assign accept_s   = bus.in_valid & ~bus.flush;
    assign last_s     = (ccnt_r == LAST_COL);
    assign complete_s = accept_s & (ccnt_r >= FIRST_FULL);
    assign win_s      = {col2_r, col1_r, col0_r};
    assign front_s    = net_front(win_s);

    // Band column counter: flush restarts, wraps at the last column of the band.
    always_comb begin
        ccnt_nxt_s = ccnt_r;
        if (bus.flush) begin
            ccnt_nxt_s = {CNT_W{1'b0}};
        end else if (accept_s) begin
            ccnt_nxt_s = last_s ? {CNT_W{1'b0}} : ccnt_r + CNT_W'(1);
        end else begin
            ccnt_nxt_s = ccnt_r;
        end
    end

    // Window shift and counter update on each accepted column.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col0_r <= {3*PIX_W{1'b0}};
            col1_r <= {3*PIX_W{1'b0}};
            col2_r <= {3*PIX_W{1'b0}};
            ccnt_r <= {CNT_W{1'b0}};
        end else begin
            ccnt_r <= ccnt_nxt_s;
            if (accept_s) begin
                col0_r <= col1_r;
                col1_r <= col2_r;
                col2_r <= col_in_s;
            end
        end
    end

    // Tag the window just captured: complete?, last of band?, and its mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_vld_r  <= 1'b0;
            win_done_r <= 1'b0;
            win_mode_r <= 2'b00;
        end else begin
            win_vld_r  <= complete_s;
            win_done_r <= complete_s & last_s;
            if (accept_s) begin
                win_mode_r <= bus.mode;
            end
        end
    end

`ifdef RANK_FILTER_PIPE_EN
    win_t       front_r;
    pix_t       centre_r;
    logic [1:0] pmode_r;
    logic       pvld_r, pdone_r;

    // Mid-network register; min/max are taken after it since the stage keeps the value set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_r  <= {9*PIX_W{1'b0}};
            centre_r <= {PIX_W{1'b0}};
            pmode_r  <= 2'b00;
            pvld_r   <= 1'b0;
            pdone_r  <= 1'b0;
        end else if (bus.flush) begin
            pvld_r  <= 1'b0;
            pdone_r <= 1'b0;
        end else begin
            pvld_r  <= win_vld_r;
            pdone_r <= win_done_r;
            if (win_vld_r) begin
                front_r  <= front_s;
                centre_r <= win_s[4];
                pmode_r  <= win_mode_r;
            end
        end
    end

    assign back_in_s  = front_r;
    assign centre_s   = centre_r;
    assign res_mode_s = pmode_r;
    assign res_vld_s  = pvld_r;
    assign res_done_s = pdone_r;
`else
    assign back_in_s  = front_s;
    assign centre_s   = win_s[4];
    assign res_mode_s = win_mode_r;
    assign res_vld_s  = win_vld_r;
    assign res_done_s = win_done_r;
`endif

    // Rank selection by the mode sampled with the completing column.
    always_comb begin
        result_s = centre_s;
        case (res_mode_s)
            2'b00:   result_s = net_back(back_in_s);
            2'b01:   result_s = tree_min(back_in_s);
            2'b10:   result_s = tree_max(back_in_s);
            2'b11:   result_s = centre_s;
            default: result_s = centre_s;
        endcase
    end

    // Output register; pixel_out holds between results, flush kills the pending one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            band_done_r <= 1'b0;
            pixel_out_r <= {PIX_W{1'b0}};
        end else if (bus.flush) begin
            out_valid_r <= 1'b0;
            band_done_r <= 1'b0;
        end else begin
            out_valid_r <= res_vld_s;
            band_done_r <= res_done_s;
            if (res_vld_s) begin
                pixel_out_r <= result_s;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.band_done = band_done_r;
    assign bus.pixel_out = pixel_out_r;
endmodule

// File: tb/tb_rank_filter_3x3.sv
// Directed self-checking bench for rank_filter_3x3 (IMG_W=16, PIX_W=5); honours RANK_FILTER_PIPE_EN.
`timescale 1ns/1ps
module tb_rank_filter_3x3;
    localparam int PIX_W = 5;
    localparam int IMG_W = 16;
`ifdef RANK_FILTER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [PIX_W-1:0] q_pix[$];
    logic             q_bd[$];

    rank_filter_3x3_if #(.PIX_W(PIX_W)) bus ();
    rank_filter_3x3 #(.PIX_W(PIX_W), .IMG_W(IMG_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Collect every emitted result for sequence-level checks.
    always @(posedge clk) begin
        #1;
        if (bus.out_valid === 1'b1) begin
            q_pix.push_back(bus.pixel_out);
            q_bd.push_back(bus.band_done);
        end
    end

    function automatic int median3(input int a, input int b, input int c);
        if (a > b) return (b > c) ? b : ((a > c) ? c : a);
        else       return (a > c) ? a : ((b > c) ? c : b);
    endfunction

    task automatic step(input logic v, input logic f, input logic [1:0] m,
                        input int a, input int b, input int c);
        bus.in_valid  = v;
        bus.flush     = f;
        bus.mode      = m;
        bus.pixel_in0 = a[PIX_W-1:0];
        bus.pixel_in1 = b[PIX_W-1:0];
        bus.pixel_in2 = c[PIX_W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'b10, i + 3, i + 9, i + 20);
        #3;
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.pixel_out !== 5'd0 || bus.band_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: out_valid=%b pixel_out=%0d band_done=%b, required 0/0/0",
                     bus.out_valid, bus.pixel_out, bus.band_done);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (bus.out_valid !== 1'b0 || bus.pixel_out !== 5'd0 || bus.band_done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: out_valid=%b pixel_out=%0d band_done=%b, required 0/0/0",
                         i, bus.out_valid, bus.pixel_out, bus.band_done);
            end
        end
    endtask

    task automatic test_median();
        step(1'b0, 1'b1, 2'b00, 0, 0, 0);
        idle(2);
        step(1'b1, 1'b0, 2'b00, 9, 1, 5);
        step(1'b1, 1'b0, 2'b00, 3, 7, 2);
        step(1'b1, 1'b0, 2'b00, 8, 4, 6);
        for (int j = 0; j <= LAT + 1; j++) begin
            if (j > 0) idle(1);
            n_tests++;
            if (j == LAT) begin
                if (bus.out_valid !== 1'b1 || bus.pixel_out !== 5'd5 || bus.band_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL median edge+%0d: valid=%b pixel=%0d done=%b, required 1/5/0",
                             j, bus.out_valid, bus.pixel_out, bus.band_done);
                end
            end else if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL median_quiet edge+%0d: valid=%b, required 0", j, bus.out_valid);
            end
        end
    endtask

    task automatic test_modes();
        logic [1:0]       modes[3];
        logic [PIX_W-1:0] expv[3];
        modes = '{2'b01, 2'b10, 2'b11};
        expv  = '{5'd1, 5'd9, 5'd7};
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 2'b00, 0, 0, 0);
            step(1'b1, 1'b0, ~modes[k], 9, 1, 5);
            step(1'b1, 1'b0, ~modes[k], 3, 7, 2);
            step(1'b1, 1'b0, modes[k], 8, 4, 6);
            for (int j = 0; j < LAT; j++) step(1'b0, 1'b0, ~modes[k], 0, 0, 0);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.pixel_out !== expv[k]) begin
                n_fail++;
                $display("FAIL mode_%b: valid=%b pixel=%0d, required 1/%0d",
                         modes[k], bus.out_valid, bus.pixel_out, expv[k]);
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [PIX_W-1:0] expv[4];
        expv = '{5'd1, 5'd9, 5'd1, 5'd5};
        step(1'b0, 1'b1, 2'b00, 0, 0, 0);
        idle(2);
        q_pix.delete();
        q_bd.delete();
        step(1'b1, 1'b0, 2'b11, 9, 1, 5);
        step(1'b1, 1'b0, 2'b10, 3, 7, 2);
        step(1'b1, 1'b0, 2'b01, 8, 4, 6);
        step(1'b1, 1'b0, 2'b10, 9, 1, 5);
        step(1'b1, 1'b0, 2'b11, 3, 7, 2);
        step(1'b1, 1'b0, 2'b00, 8, 4, 6);
        idle(LAT + 2);
        n_tests++;
        if (q_pix.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs, required 4", q_pix.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (k >= q_pix.size() || q_pix[k] !== expv[k]) begin
                n_fail++;
                $display("FAIL b2b_value[%0d]: got %0d, required %0d",
                         k, (k < q_pix.size()) ? q_pix[k] : 5'd0, expv[k]);
            end
        end
    endtask

    task automatic test_band_wrap();
        int  ev;
        logic eb;
        step(1'b0, 1'b1, 2'b00, 0, 0, 0);
        idle(2);
        q_pix.delete();
        q_bd.delete();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 2'b00, i % 32, i % 32, i % 32);
        idle(LAT + 2);
        n_tests++;
        if (q_pix.size() != 28) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d outputs, required 28", q_pix.size());
        end
        for (int k = 0; k < 28; k++) begin
            ev = (k < 14) ? k + 1 : k + 3;
            eb = (k == 13) || (k == 27);
            n_tests++;
            if (k >= q_pix.size()) begin
                n_fail++;
                $display("FAIL wrap_missing[%0d]: no output, required %0d", k, ev);
            end else if (q_pix[k] !== PIX_W'(ev) || q_bd[k] !== eb) begin
                n_fail++;
                $display("FAIL wrap_out[%0d]: got %0d done=%b, required %0d done=%b",
                         k, q_pix[k], q_bd[k], ev, eb);
            end
        end
    endtask

    task automatic test_stall();
        int   col, ccnt_m, w1, w2, n_out, exp_v;
        logic v, comp, exp_o, exp_bd;
        logic [2:0] hist;
        int   exp_q[$];
        logic bd_q[$];
        col = 0; ccnt_m = 0; w1 = 0; w2 = 0; n_out = 0; hist = 3'b000; exp_v = 0; exp_bd = 1'b0;
        step(1'b0, 1'b1, 2'b00, 0, 0, 0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            v    = (col < 32) && ($urandom_range(0, 3) != 0);
            comp = v && (ccnt_m >= 2);
            if (comp) begin
                exp_q.push_back(median3(w2, w1, col));
                bd_q.push_back(ccnt_m == IMG_W - 1);
            end
            if (v) begin
                step(1'b1, 1'b0, 2'b00, col, col, col);
                w2 = w1;
                w1 = col;
                ccnt_m = (ccnt_m == IMG_W - 1) ? 0 : ccnt_m + 1;
                col++;
            end else begin
                step(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31));
            end
            hist  = {hist[1:0], comp};
            exp_o = hist[LAT];
            if (exp_o) begin
                exp_v  = exp_q.pop_front();
                exp_bd = bd_q.pop_front();
                n_out++;
            end
            n_tests++;
            if (bus.out_valid !== exp_o) begin
                n_fail++;
                $display("FAIL stall_valid cyc %0d: got %b, required %b", cyc, bus.out_valid, exp_o);
            end else if (exp_o && (bus.pixel_out !== PIX_W'(exp_v) || bus.band_done !== exp_bd)) begin
                n_fail++;
                $display("FAIL stall_out cyc %0d: got %0d done=%b, required %0d done=%b",
                         cyc, bus.pixel_out, bus.band_done, exp_v, exp_bd);
            end
        end
        n_tests++;
        if (n_out != 28) begin
            n_fail++;
            $display("FAIL stall_count: got %0d expected outputs, required 28", n_out);
        end
    endtask

    task automatic test_flush();
        int   vals[14];
        int   ccnt_m, w1, w2, n_post, last_v, exp_v;
        logic v, f, comp, exp_o;
        logic [2:0] hist;
        int   exp_q[$];
        vals = '{0, 0, 2, 4, 6, 8, 31, 20, 21, 22, 0, 0, 0, 0};
        ccnt_m = 0; w1 = 0; w2 = 0; n_post = 0; last_v = 0; exp_v = 0; hist = 3'b000;
        for (int idx = 0; idx < 14; idx++) begin
            v = (idx >= 1) && (idx <= 9);
            f = (idx == 0) || (idx == 6);
            if (f) begin
                hist = 3'b000;
                exp_q.delete();
                ccnt_m = 0;
            end else begin
                comp = v && (ccnt_m >= 2);
                if (comp) exp_q.push_back(median3(w2, w1, vals[idx]));
                if (v) begin
                    w2 = w1;
                    w1 = vals[idx];
                    ccnt_m = (ccnt_m == IMG_W - 1) ? 0 : ccnt_m + 1;
                end
                hist = {hist[1:0], comp};
            end
            step(v, f, 2'b00, vals[idx], vals[idx], vals[idx]);
            exp_o = hist[LAT];
            if (exp_o) exp_v = exp_q.pop_front();
            if (bus.out_valid === 1'b1 && idx > 6) begin
                n_post++;
                last_v = int'(bus.pixel_out);
            end
            n_tests++;
            if (bus.out_valid !== exp_o || (exp_o && bus.pixel_out !== PIX_W'(exp_v))) begin
                n_fail++;
                $display("FAIL flush step %0d: valid=%b pixel=%0d, required valid=%b pixel=%0d",
                         idx, bus.out_valid, bus.pixel_out, exp_o, exp_v);
            end
        end
        n_tests++;
        if (n_post != 1 || last_v != 21) begin
            n_fail++;
            $display("FAIL flush_after: %0d outputs last=%0d, required 1 output of 21", n_post, last_v);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.mode      = 2'b00;
        bus.pixel_in0 = 5'd0;
        bus.pixel_in1 = 5'd0;
        bus.pixel_in2 = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_median();
        test_modes();
        test_back_to_back();
        test_band_wrap();
        test_stall();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rank_filter_3x3.md
# rank_filter_3x3

Parametrised 3x3 rank-order filter for the image-processing pipeline. It accepts one three-pixel column per valid cycle, keeps a sliding 3x3 window and outputs the median, minimum, maximum or centre pixel of that window. Output is produced only for windows lying fully inside the current row band. A per-column valid handshake and a band column counter replace the free-running load/operate/over sequencing of the previous median filter, so the block can sit behind a stalling line-buffer controller.

## Interface
- `PIX_W`, default 5: pixel bit width.
- `IMG_W`, default 16: columns per row band. Legal range is 3 and up.
- `CNT_W`, default `$clog2(IMG_W)`: column counter width. Derived; do not override.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: column present on `pixel_in0..2` this cycle.
- `pixel_in0`, `pixel_in1`, `pixel_in2`, in, `PIX_W` each: top, middle and bottom pixel of the incoming column.
- `mode`, in, 2: operation, sampled with the column. 00 = median, 01 = min, 10 = max, 11 = centre pass-through.
- `flush`, in, 1: synchronous band restart.
- `out_valid`, out, 1: `pixel_out` holds a new result.
- `pixel_out`, out, `PIX_W`: filtered pixel.
- `band_done`, out, 1: high together with `out_valid` for the last window of a band.

## Operation
- **Window:** three column registers, col0 (oldest), col1 and col2 (newest).
  - On an accepted column (`in_valid` high, `flush` low): col0 takes col1, col1 takes col2, col2 takes the input.
  - If `in_valid` is low, the window holds.
- **Column counter `ccnt`:**
  - Increments on each accepted column.
  - Wraps from `IMG_W-1` to 0, which starts a new band.
  - Window registers are not cleared at wrap. Old columns are simply masked by the fill rule below.
- **Fill rule:** the window is complete when the accepted column had `ccnt` ≥ 2 (pre-increment value). Only complete windows produce `out_valid`. This gives `IMG_W-2` outputs per band.
- **band_done:** asserted on the output of the window completed by the column with `ccnt == IMG_W-1`.
- **Rank logic:** purely combinational, on unsigned values.
  - Median uses the 19-comparator 3x3 median network.
  - Min and max use comparator trees.
  - Centre selects col1 middle.
  - The result is always exactly `PIX_W` bits and is always one of the nine window values.
- **Mode:** registered alongside the column that completes the window. Changing `mode` every cycle is legal; each output uses the mode sampled with its completing column.
- **flush:**
  - Sets `ccnt` to 0.
  - Kills any in-flight result: `out_valid` is 0 at the next edge, plus the pipe stage if present.
  - Discards the column presented in the same cycle (flush beats `in_valid`).
  - Window contents are left as is.
- **Reset:** clears the window to 0, `ccnt` to 0, `pixel_out` to 0, `out_valid` to 0 and `band_done` to 0. Reset asserted mid-band discards everything in flight.

## Timing
- The column that completes a window is captured at edge k.
- `pixel_out`, `out_valid` and `band_done` are registered and update at edge k+1, so the result is visible during cycle k+1.
- `out_valid` is a single-cycle pulse per completing column. Back-to-back valid columns give back-to-back outputs.
- `pixel_out` holds its last value when `out_valid` is low.
- There is no backpressure input. Downstream must accept every `out_valid`.
- With `RANK_FILTER_PIPE_EN`, latency is 2 edges (see Configuration). All handshake rules are otherwise unchanged.

## Configuration
- `RANK_FILTER_PIPE_EN` defined:
  - Inserts a register between network stage 4 and stage 5. This covers all modes, and min/max/centre are delayed to match.
  - Latency becomes 2 edges: result at edge k+2.
  - `out_valid`, `band_done` and mode are carried through the extra stage.
  - `flush` also clears the stage-valid bit.
- `RANK_FILTER_PIPE_EN` undefined: single output register, latency 1 edge.

## Test plan
- **Reset state:** assert `reset` mid-stream, release it, apply no input. Required: `out_valid` = 0, `pixel_out` = 0 and `band_done` = 0 for 10 cycles.
- **Median:** `IMG_W`=16, `PIX_W`=5, mode 00. Feed columns (9,1,5), (3,7,2), (8,4,6) back-to-back. Required: one `out_valid` pulse with `pixel_out` = 5, one edge after the third column (two edges with PIPE_EN).
- **Modes:** same three columns repeated with mode 01, then 10, then 11 on the completing column. Required: `pixel_out` = 1, then 9, then 7.
- **Band wrap:** 32 consecutive valid columns, each with all three pixels equal to the column index mod 32 (0..31). Required:
  - 14 outputs per band.
  - `band_done` coincides with median 14 (window of columns 13..15).
  - No output for the columns with index 16 and 17 after wrap.
  - The next output is 17 (window of columns 16..18).
- **Stall:** insert random `in_valid` = 0 gaps between columns. Required: identical output sequence, with `out_valid` never asserted without a preceding accepted completing column.
- **Flush:** assert `flush` together with `in_valid` at `ccnt`=5. Required:
  - The column is discarded.
  - The pending result is suppressed.
  - The next two accepted columns give no output.
  - The third accepted column gives an output.
